// File: rtl/fetch_pcgen_q.sv
// Next-PC generator plus fetch-address FIFO toward decode.
// Define FETCH_PERF_CNT_EN to add redirect/stall performance counters.
module fetch_pcgen_q #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned FETCH_BYTES = 16,
  parameter logic [63:0] RESET_PC    = 64'h8000_0000,
  parameter int unsigned QDEPTH      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_restart_vld,
  input  logic [ADDR_W-1:0] io_restart_adr,
  input  logic              io_be_br_vld,
  input  logic [ADDR_W-1:0] io_be_br_adr,
  input  logic              io_fe_br_vld,
  input  logic [ADDR_W-1:0] io_fe_br_adr,
  output logic              io_fetch_req,
  output logic [ADDR_W-1:0] io_fetch_adr,
  output logic [ADDR_W-1:0] io_fetch_nadr,
  input  logic              io_fetch_ack,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       io_perf_redirects,
  output logic [31:0]       io_perf_stall,
`endif
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] BLK = ADDR_W'(FETCH_BYTES);
  localparam logic [ADDR_W-1:0] MASK = ~(BLK - 1'b1);
  localparam logic [PW:0] DEPTH = (PW+1)'(QDEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              started_q;
  logic [PW:0]       cnt_q, cnt_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [ADDR_W-1:0] mem_q [QDEPTH];

  logic              redir;
  logic              full;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] nadr;
  logic [ADDR_W-1:0] tgt;

  assign redir = io_restart_vld | io_be_br_vld | io_fe_br_vld;
  assign full  = (cnt_q == DEPTH);
  assign nadr  = (pc_q & MASK) + BLK;

  assign io_fetch_req  = started_q & ~full & ~redir;
  assign io_fetch_adr  = pc_q;
  assign io_fetch_nadr = nadr;

  assign push = io_fetch_req & io_fetch_ack;
  assign pop  = out_valid & out_ready;

  assign out_valid = (cnt_q != '0);
  assign out_pc    = out_valid ? mem_q[rptr_q] : '0;

  always_comb begin
    tgt = io_fe_br_adr;
    if (io_restart_vld)    tgt = io_restart_adr;
    else if (io_be_br_vld) tgt = io_be_br_adr;
  end

  // A redirect flushes the queue; it overrides any pop in that cycle.
  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (redir) begin
      pc_d   = tgt;
      cnt_d  = '0;
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) begin
        pc_d   = nadr;
        wptr_d = wptr_q + 1'b1;
      end
      if (pop) rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q      <= RST_PC;
      started_q <= 1'b0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      started_q <= 1'b1;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= pc_q;
  end

  a_no_push_full: assert property (
    @(posedge clock) disable iff (reset) !(push && full)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirs_q;
  logic [31:0] stall_q;
  logic        stall;

  assign stall = started_q & ~io_fetch_req & ~redir;
  assign io_perf_redirects = redirs_q;
  assign io_perf_stall     = stall_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      redirs_q <= '0;
      stall_q  <= '0;
    end else begin
      if (redir && !(&redirs_q)) redirs_q <= redirs_q + 1'b1;
      if (stall && !(&stall_q))  stall_q  <= stall_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pcgen_q.sv
// Directed table-driven bench for fetch_pcgen_q.
// Each vector: inputs for one cycle plus the outputs expected in it.
module tb_fetch_pcgen_q;

  typedef logic [63:0] a_t;

  typedef struct {
    logic rv; a_t ra;
    logic bv; a_t ba;
    logic fv; a_t fa;
    logic ack; logic rdy;
    logic req; a_t adr; a_t nadr;
    logic vld; a_t pc;
  } vec_t;

  localparam a_t P = 64'h8000_0000;
  localparam a_t TOP = 64'hFFFF_FFFF_FFFF_FFF0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rv = 1'b0, bv = 1'b0, fv = 1'b0;
  a_t   ra = '0, ba = '0, fa = '0;
  logic ack = 1'b1, rdy = 1'b1;
  logic req, vld;
  a_t   adr, nadr, pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_r, perf_s;
`endif

  int nvec = 0;
  int nbad = 0;
  vec_t tbl[$];

  fetch_pcgen_q dut (
    .clock(clock),
    .reset(reset),
    .io_restart_vld(rv),
    .io_restart_adr(ra),
    .io_be_br_vld(bv),
    .io_be_br_adr(ba),
    .io_fe_br_vld(fv),
    .io_fe_br_adr(fa),
    .io_fetch_req(req),
    .io_fetch_adr(adr),
    .io_fetch_nadr(nadr),
    .io_fetch_ack(ack),
`ifdef FETCH_PERF_CNT_EN
    .io_perf_redirects(perf_r),
    .io_perf_stall(perf_s),
`endif
    .out_valid(vld),
    .out_pc(pc),
    .out_ready(rdy)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(
    input logic [2:0] m, input a_t r_a,
    input a_t b_a, input a_t f_a,
    input logic k, input logic y,
    input logic e_req, input a_t e_adr,
    input a_t e_nadr, input logic e_vld,
    input a_t e_pc);
    vec_t v;
    v.rv = m[2]; v.ra = r_a;
    v.bv = m[1]; v.ba = b_a;
    v.fv = m[0]; v.fa = f_a;
    v.ack = k; v.rdy = y;
    v.req = e_req; v.adr = e_adr;
    v.nadr = e_nadr; v.vld = e_vld;
    v.pc = e_pc;
    return v;
  endfunction

  // Plain sequential cycle: no redirect.
  function automatic vec_t sq(
    input logic k, input logic y,
    input logic e_req, input a_t e_adr,
    input logic e_vld, input a_t e_pc);
    a_t nx;
    nx = (e_adr & ~a_t'(15)) + a_t'(16);
    return mk(3'b000, '0, '0, '0, k, y,
              e_req, e_adr, nx, e_vld, e_pc);
  endfunction

  task automatic chk(input int id, input vec_t v);
    nvec++;
    if (req !== v.req || adr !== v.adr ||
        nadr !== v.nadr || vld !== v.vld ||
        pc !== v.pc) begin
      nbad++;
      $display("FAIL vec%0d: got req=%0b adr=%h nadr=%h vld=%0b pc=%h, want req=%0b adr=%h nadr=%h vld=%0b pc=%h",
        id, req, adr, nadr, vld, pc,
        v.req, v.adr, v.nadr, v.vld, v.pc);
    end
  endtask

  // Entered at posedge+1; checks at the falling edge.
  task automatic step(input int id, input vec_t v);
    rv = v.rv; ra = v.ra;
    bv = v.bv; ba = v.ba;
    fv = v.fv; fa = v.fa;
    ack = v.ack; rdy = v.rdy;
    #4;
    chk(id, v);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    vec_t rst_v;
    rst_v = sq(1, 1, 0, P, 0, '0);

    // Startup stream with out_ready=1
    tbl.push_back(sq(1, 1, 0, P, 0, '0));
    tbl.push_back(sq(1, 1, 1, P, 0, '0));
    tbl.push_back(sq(1, 1, 1, P+'h10, 1, P));
    tbl.push_back(sq(1, 1, 1, P+'h20, 1, P+'h10));
    tbl.push_back(sq(1, 1, 1, P+'h30, 1, P+'h20));
    tbl.push_back(mk(3'b100, P, '0, '0, 1, 1,
                     0, P+'h40, P+'h50, 1, P+'h30));
    // Fill with out_ready=0
    tbl.push_back(sq(1, 0, 1, P, 0, '0));
    tbl.push_back(sq(1, 0, 1, P+'h10, 1, P));
    tbl.push_back(sq(1, 0, 1, P+'h20, 1, P));
    tbl.push_back(sq(1, 0, 1, P+'h30, 1, P));
    tbl.push_back(sq(1, 0, 0, P+'h40, 1, P));
    tbl.push_back(sq(1, 0, 0, P+'h40, 1, P));
    // Drain
    tbl.push_back(sq(0, 1, 0, P+'h40, 1, P));
    tbl.push_back(sq(0, 1, 1, P+'h40, 1, P+'h10));
    tbl.push_back(sq(0, 1, 1, P+'h40, 1, P+'h20));
    tbl.push_back(sq(0, 1, 1, P+'h40, 1, P+'h30));
    // Two entries, then triple redirect
    tbl.push_back(sq(1, 0, 1, P+'h40, 0, '0));
    tbl.push_back(sq(1, 0, 1, P+'h50, 1, P+'h40));
    tbl.push_back(mk(3'b111, 'h1000, 'h2000, 'h3000,
                     1, 0, 0, P+'h60, P+'h70, 1, P+'h40));
    tbl.push_back(mk(3'b000, '0, '0, '0, 0, 1,
                     1, 'h1000, 'h1010, 0, '0));
    // Unaligned frontend redirect
    tbl.push_back(mk(3'b001, '0, '0, P+'h104, 1, 1,
                     0, 'h1000, 'h1010, 0, '0));
    tbl.push_back(mk(3'b000, '0, '0, '0, 1, 1,
                     1, P+'h104, P+'h110, 0, '0));
    tbl.push_back(sq(1, 1, 1, P+'h110, 1, P+'h104));
    tbl.push_back(sq(0, 1, 1, P+'h120, 1, P+'h110));
    tbl.push_back(sq(0, 1, 1, P+'h120, 0, '0));

    rv = 0; bv = 0; fv = 0; ack = 1; rdy = 1;
    @(posedge clock);
    #1;
    chk(0, rst_v);
    @(posedge clock);
    #1;
    reset = 1'b0;

    foreach (tbl[i]) step(i + 1, tbl[i]);

    // Long ack stall: adr held, nothing pushed
    for (int k = 0; k < 10; k++)
      step(200 + k, sq(0, 1, 1, P+'h120, 0, '0));

    // be_br beats fe_br; wrap at top of address space
    step(300, mk(3'b011, '0, TOP, 'h5000, 1, 1,
                 0, P+'h120, P+'h130, 0, '0));
    step(301, mk(3'b000, '0, '0, '0, 1, 0,
                 1, TOP, '0, 0, '0));
    step(302, sq(1, 0, 1, '0, 1, TOP));
    step(303, sq(1, 0, 1, 'h10, 1, TOP));

    // Asynchronous reset with three queued entries
    reset = 1'b1;
    #1;
    chk(400, rst_v);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(401, sq(1, 1, 0, P, 0, '0));
    step(402, sq(1, 1, 1, P, 0, '0));
    step(403, sq(1, 1, 1, P+'h10, 1, P));

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule

// File: doc/fetch_pcgen_q.md
Name: fetch_pcgen_q

Overview:
- Parametrised next-PC generator and fetch-address queue for the front end.
- Issues fetch requests to the ICU over a req/ack bus and steps the PC sequentially in fetch-block strides.
- Accepts three prioritised redirect buses and buffers fetched-block PCs in a QDEPTH-entry FIFO toward decode, with ready/valid output.
- Generalises the 2-stage fetch with configurable address width, fetch block size, reset vector and queue depth, plus explicit redirect priority and queue flush.

Parameters:
- ADDR_W, 64, address width in bits.
- FETCH_BYTES, 16, fetch block size in bytes; power of 2, >=4.
- RESET_PC, 64'h8000_0000, PC after reset; truncated to ADDR_W.
- QDEPTH, 4, output queue entries; power of 2, >=2.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- io_restart_vld  in  1  restart redirect (highest priority).
- io_restart_adr  in  ADDR_W  restart target.
- io_be_br_vld  in  1  backend branch redirect.
- io_be_br_adr  in  ADDR_W  backend target.
- io_fe_br_vld  in  1  frontend branch redirect (lowest priority).
- io_fe_br_adr  in  ADDR_W  frontend target.
- io_fetch_req  out  1  fetch request to ICU.
- io_fetch_adr  out  ADDR_W  current fetch PC.
- io_fetch_nadr  out  ADDR_W  next sequential block address.
- io_fetch_ack  in  1  ICU accepts the request this cycle.
- out_valid  out  1  queue head valid.
- out_pc  out  ADDR_W  queue head PC.
- out_ready  in  1  consumer accepts head.

Behaviour:
- Reset (asynchronous, immediate):
  - pc=RESET_PC, started=0, queue count/pointers=0.
  - Outputs: io_fetch_req=0, io_fetch_adr=RESET_PC, out_valid=0, out_pc=0.
- started sets to 1 on the first rising edge after reset deasserts.
- io_fetch_req = started & (count < QDEPTH) & no redirect valid this cycle.
  - count is the registered value; a pop in the same cycle does not enable req.
- io_fetch_adr = pc.
- io_fetch_nadr = (pc & ~(FETCH_BYTES-1)) + FETCH_BYTES, modulo 2^ADDR_W (wraps to 0).
- Accepted fetch (req & ack, no redirect): push pc into the queue, then pc <= nadr on the same edge.
- req held with ack=0: pc and adr remain stable indefinitely.
- Redirect in a cycle where any *_vld is high:
  - Target chosen by priority restart > be_br > fe_br; pc <= that target, kept unaligned.
  - Queue flushed: count=0 and pointers reset; out_valid=0 the next cycle.
  - req=0 that cycle; any ack that cycle is ignored and nothing is pushed.
  - Pop that cycle is allowed but irrelevant, since the flush wins.
- First sequential address after an unaligned redirect is the aligned next block.
- Queue:
  - out_valid = count != 0; out_pc = head entry, or 0 when empty.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo QDEPTH.
  - A push when full is impossible by construction; assertion required.
- Latency: PC accepted at edge N is visible on out_pc after edge N (next cycle).
- Reset asserted mid-operation: all state is cleared immediately per the reset values, and the queue contents are lost.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs io_perf_redirects (32 bits) and io_perf_stall (32 bits), both reset to 0.
  - io_perf_redirects increments on each redirect cycle.
  - io_perf_stall increments each cycle with started & !io_fetch_req & no redirect.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset released, ack=1, out_ready=1 (defaults) -> out_valid first high in the cycle after the first accepted fetch; out_pc sequence 0x80000000, 0x80000010, 0x80000020, 0x80000030 on consecutive cycles.
- out_ready=0, ack=1 -> exactly 4 pushes; then req=0 with adr=0x80000040 held. Set out_ready=1 -> pops 0x80000000..0x80000030 in order, and req reasserts the cycle after count<4.
- Redirect priority: restart=0x1000, be_br=0x2000 and fe_br=0x3000 valid in one cycle with ack=1 and queue holding 2 entries -> no push, out_valid=0 next cycle, next fetch_adr=0x1000, nadr=0x1010.
- Unaligned target: fe_br_adr=0x80000104 -> fetch_adr=0x80000104, nadr=0x80000110; after ack, fetch_adr=0x80000110, and out_pc shows 0x80000104 then 0x80000110.
- Stall and wrap: ack=0 for 10 cycles -> adr stable, no push. Redirect to 0xFFFF_FFFF_FFFF_FFF0 with ack=1 -> next adr=0x0.
- Reset mid-stream with 3 queued entries -> out_valid=0 and io_fetch_req=0 immediately, without waiting for a clock edge; after release, fetching restarts at 0x80000000.
